// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared register offsets, STATUS bit indices and FSM states for mmio_uart_tx
package mmio_uart_tx_pkg;

    // Word offsets (mem_addr[3:2]) within the 16-byte register window
    localparam logic [1:0] UART_REG_TXDATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS   = 2'd1;
    localparam logic [1:0] UART_REG_BAUD_DIV = 2'd2;

    // STATUS register bit positions
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_LEVEL_LSB = 8;

    // Transmit FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Bit-time down-counter reload value; a divisor of 0 behaves like 1
    function automatic logic [15:0] bit_count_init(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with occupancy level, async active-low reset
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr];

    // Storage array: written on push, no reset needed since level gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks push minus pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined)
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wenable,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        irq_tx_empty
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    offset;
    logic          wr_cycle;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_clear;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [7:0]    fifo_rdata;

    logic          overflow_q;
    logic [15:0]   baud_div_q;

    tx_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          irq_q;

    logic          unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wenable[3:2]};

    assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = mem_addr[3:2];
    assign wr_cycle  = sel && (mem_wenable != 4'b0000);
    assign push_req  = wr_cycle && (offset == UART_REG_TXDATA) && mem_wenable[0];
    assign push      = push_req && !fifo_full;
    assign ovf_clear = wr_cycle && (offset == UART_REG_STATUS) && mem_wenable[0]
                       && mem_wdata[STAT_OVERFLOW];

    assign tx           = tx_q;
    assign irq_tx_empty = irq_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_wdata[7:0]),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Side-effect-free read mux; zero when unselected so the fabric can OR it with RAM
    always_comb begin
        mem_rdata = 32'h0;
        if (sel) begin
            case (offset)
                UART_REG_STATUS: begin
                    mem_rdata[STAT_FULL]                 = fifo_full;
                    mem_rdata[STAT_EMPTY]                = fifo_empty;
                    mem_rdata[STAT_BUSY]                 = (state_q != ST_IDLE);
                    mem_rdata[STAT_OVERFLOW]             = overflow_q;
                    mem_rdata[STAT_LEVEL_LSB +: LW]      = fifo_level;
                end
                UART_REG_BAUD_DIV: mem_rdata[15:0] = baud_div_q;
                default:           mem_rdata = 32'h0;
            endcase
        end
    end

    // CPU-visible registers: overflow sticky flag and byte-lane-writable baud divisor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            baud_div_q <= DEFAULT_DIV;
        end else begin
            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (ovf_clear) begin
                overflow_q <= 1'b0;
            end
            if (wr_cycle && (offset == UART_REG_BAUD_DIV)) begin
                if (mem_wenable[0]) begin
                    baud_div_q[7:0] <= mem_wdata[7:0];
                end
                if (mem_wenable[1]) begin
                    baud_div_q[15:8] <= mem_wdata[15:8];
                end
            end
        end
    end

    // Next-state logic: each bit lasts until the down-counter reaches zero, then the counter reloads
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q == ST_IDLE) begin
            tx_d  = 1'b1;
            cnt_d = 16'd0;
            if (!fifo_empty) begin
                pop     = 1'b1;
                data_d  = fifo_rdata;
                state_d = ST_START;
                tx_d    = 1'b0;
                cnt_d   = bit_count_init(baud_div_q);
                bit_d   = 3'd0;
            end
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = bit_count_init(baud_div_q);
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                end
                ST_DATA: begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
                ST_STOP: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        cnt_d   = 16'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // FSM state, baud counter, frame data and registered serial/interrupt outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            irq_q   <= fifo_empty && (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a frame-level reference model
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int FBITS = 10;
    localparam bit PAR   = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wenable;
    logic [31:0] mem_rdata;
    logic        tx;
    logic        irq_tx_empty;

    int errors;
    int checks;

    mmio_uart_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wenable  (mem_wenable),
        .mem_rdata    (mem_rdata),
        .tx           (tx),
        .irq_tx_empty (irq_tx_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Store presented during one cycle; returns 1 time unit after the capturing edge
    task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        mem_addr    = BASE | {28'h0, off, 2'b00};
        mem_wdata   = data;
        mem_wenable = be;
        @(posedge clk);
        #1;
        mem_wenable = 4'b0000;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr    = addr;
        mem_wenable = 4'b0000;
        #1;
        data     = mem_rdata;
        mem_addr = 32'h0;
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0)               return 1'b0;
        if (j >= 1 && j <= 8)     return b[j-1];
        if (j == 9 && PAR)        return ^b;
        return 1'b1;
    endfunction

    // Checks nb consecutive frames sample-by-sample, then the idle state right after
    task automatic check_stream(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input int nb, input int div, input bit first_now);
        int eff;
        int flen;
        int total;
        logic [7:0] b;
        logic [31:0] rd;
        eff   = (div == 0) ? 1 : div;
        flen  = FBITS * eff;
        total = nb * flen;
        for (int k = 0; k <= total; k++) begin
            if (!(k == 0 && first_now)) begin
                @(posedge clk);
                #1;
            end
            if (k < total) begin
                b = (k < flen) ? b0 : b1;
                check(tag, {31'h0, tx}, {31'h0, frame_bit(b, (k % flen) / eff)});
            end else begin
                check({tag, "_idle_tx"}, {31'h0, tx}, 32'h1);
                check({tag, "_idle_irq"}, {31'h0, irq_tx_empty}, 32'h1);
                bus_read(BASE + 32'h4, rd);
                check({tag, "_idle_status"}, rd, 32'h0000_0002);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  rb;
        int          rdiv;
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_wenable = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_irq", {31'h0, irq_tx_empty}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(BASE + 32'h4, rd);
        check("rst_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd);
        check("rst_baud", rd, 32'd868);

        // Unselected and reserved reads
        bus_read(BASE + 32'h20, rd);
        check("rd_outside", rd, 32'h0);
        bus_read(32'h0, rd);
        check("rd_zero", rd, 32'h0);
        bus_read(BASE + 32'h0, rd);
        check("rd_txdata", rd, 32'h0);

        // BAUD_DIV byte lanes and ignored reserved write
        bus_write(2'd2, 32'h0000_ABCD, 4'b0010);
        bus_read(BASE + 32'h8, rd);
        check("baud_lane1", rd, 32'h0000_AB64);
        bus_write(2'd2, 32'h0000_0012, 4'b0001);
        bus_read(BASE + 32'h8, rd);
        check("baud_lane0", rd, 32'h0000_AB12);
        bus_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
        bus_read(BASE + 32'h8, rd);
        check("resv_wr_baud", rd, 32'h0000_AB12);
        bus_read(BASE + 32'hC, rd);
        check("resv_rd", rd, 32'h0);

        // Single frame 0x55 at DIV=4
        bus_write(2'd2, 32'd4, 4'b1111);
        bus_write(2'd0, 32'h55, 4'b0001);
        check_stream("frame55", 8'h55, 8'h00, 1, 4, 1'b0);

        // Frame 0x07 (parity bit 1 when parity is enabled)
        bus_write(2'd0, 32'h07, 4'b0001);
        check_stream("frame07", 8'h07, 8'h00, 1, 4, 1'b0);

        // Random bytes and divisors, including DIV=0
        for (int n = 0; n < 5; n++) begin
            rb   = 8'($urandom_range(0, 255));
            rdiv = (n == 0) ? 0 : int'($urandom_range(1, 5));
            bus_write(2'd2, 32'(rdiv), 4'b0011);
            bus_write(2'd0, {24'h0, rb}, 4'b0001);
            check_stream("frame_rand", rb, 8'h00, 1, rdiv, 1'b0);
        end

        // Back-to-back frames at DIV=2, no idle gap
        bus_write(2'd2, 32'd2, 4'b0011);
        bus_write(2'd0, 32'hA5, 4'b0001);
        bus_write(2'd0, 32'h3C, 4'b0001);
        check_stream("b2b", 8'hA5, 8'h3C, 2, 2, 1'b1);

        // Asynchronous reset during data bit 3 of 0x96 (bit 3 is 0)
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd0, 32'h96, 4'b0001);
        repeat (18) @(posedge clk);
        #1;
        check("pre_rst_bit", {31'h0, tx}, {31'h0, frame_bit(8'h96, 4)});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'h0, tx}, 32'h1);
        check("async_rst_irq", {31'h0, irq_tx_empty}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(BASE + 32'h4, rd);
        check("post_rst_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd);
        check("post_rst_baud", rd, 32'd868);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_tx", {31'h0, tx}, 32'h1);

        // Overflow: one byte in flight at DIV=1000, then 9 more stores into 8 entries
        bus_write(2'd2, 32'd1000, 4'b0011);
        bus_write(2'd0, 32'h11, 4'b0001);
        for (int n = 0; n < 4; n++) begin
            bus_write(2'd0, 32'(8'h20 + n), 4'b0001);
        end
        bus_read(BASE + 32'h4, rd);
        check("fill4_status", rd, 32'h0000_0404);
        for (int n = 4; n < 9; n++) begin
            bus_write(2'd0, 32'(8'h20 + n), 4'b0001);
        end
        bus_read(BASE + 32'h4, rd);
        check("full_status", rd, 32'h0000_080D);
        check("full_tx_start", {31'h0, tx}, 32'h0);

        // Overflow clear needs lane 0; other STATUS bits unchanged
        bus_write(2'd1, 32'h0000_0008, 4'b0010);
        bus_read(BASE + 32'h4, rd);
        check("ovf_lane1_noclear", rd, 32'h0000_080D);
        bus_write(2'd1, 32'h0000_0008, 4'b0001);
        bus_read(BASE + 32'h4, rd);
        check("ovf_cleared", rd, 32'h0000_0805);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
